// File: rtl/skinny_masked_pkg.sv
// Shared constants, FSM encoding and S-box reference table for the masked SKINNY-64 datapath.
// Latency: none (package only).
// Backpressure: none (package only).
package skinny_masked_pkg;

  localparam int NIBBLES  = 16;
  localparam int SBOX_LAT = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } layer_state_t;

  // SKINNY-64 S-box, entry k in bits [4k+3:4k]: c,6,9,0,1,a,2,b,3,8,5,d,4,e,7,f
  localparam logic [63:0] SKINNY_SBOX_TABLE = 64'hF7E4D583B2A1096C;

  function automatic logic [3:0] skinny_sbox_ref(input logic [3:0] x);
    logic [63:0] tab;
    tab = SKINNY_SBOX_TABLE;
    return tab[{x, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/skinny_sbox_layer_serial_core.sv
// 3-share masked SKINNY-64 S-box core: two DOM AND stages, then output delay registers.
// Latency: LAT cycles (LAT >= 3), fully pipelined, one nibble per cycle.
// Backpressure: none; a new nibble and 8 fresh random bits are taken every cycle.
module skinny_sbox_layer_serial_core #(
  parameter int LAT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] in1,
  input  logic [3:0] in2,
  input  logic [3:0] in3,
  input  logic [7:0] rnd,
  output logic [3:0] out1,
  output logic [3:0] out2,
  output logic [3:0] out3
);

  // The S-box is four rounds of x0 ^= NOR(x3, x2) with a left rotate between rounds.
  // Unrolled: t1 = a0^NOR(a3,a2), t2 = a3^NOR(a2,a1), t3 = a2^NOR(a1,t1),
  // t4 = a1^NOR(t1,t2), result {t1,t2,t3,t4}. t1/t2 need only the inputs, t3/t4 need t1/t2,
  // giving two AND stages. NOR(a,b) = (~a)&(~b); inverting share 1 alone inverts the value.

  // Three-share DOM AND; the third pairwise mask is derived from the other two so each
  // AND needs only two fresh bits. Returns {share3, share2, share1}.
  function automatic logic [2:0] dom_and(input logic x1, input logic x2, input logic x3,
                                         input logic y1, input logic y2, input logic y3,
                                         input logic r01, input logic r12);
    logic       r02;
    logic [2:0] z;
    r02  = r01 ^ r12;
    z[0] = (x1 & y1) ^ (x1 & y2) ^ r01 ^ (x1 & y3) ^ r02;
    z[1] = (x2 & y2) ^ (x2 & y1) ^ r01 ^ (x2 & y3) ^ r12;
    z[2] = (x3 & y3) ^ (x3 & y1) ^ r02 ^ (x3 & y2) ^ r12;
    return z;
  endfunction

  // Stage-1 register per share: [3]=t1, [2]=t2, [1]=a2, [0]=a1
  logic [3:0] p1_1_q, p1_2_q, p1_3_q;
  logic [3:0] p1_1_d, p1_2_d, p1_3_d;
  // Stage-2 register per share: {t1,t2,t3,t4}
  logic [3:0] p2_1_q, p2_2_q, p2_3_q;
  logic [3:0] p2_1_d, p2_2_d, p2_3_d;
  logic [11:0] dly_q [LAT-2];

  // First AND stage: t1 and t2 from the input shares
  always_comb begin
    logic [2:0] n32, n21;
    n32 = dom_and(~in1[3], in2[3], in3[3], ~in1[2], in2[2], in3[2], rnd[0], rnd[1]);
    n21 = dom_and(~in1[2], in2[2], in3[2], ~in1[1], in2[1], in3[1], rnd[2], rnd[3]);
    p1_1_d = {in1[0] ^ n32[0], in1[3] ^ n21[0], in1[2], in1[1]};
    p1_2_d = {in2[0] ^ n32[1], in2[3] ^ n21[1], in2[2], in2[1]};
    p1_3_d = {in3[0] ^ n32[2], in3[3] ^ n21[2], in3[2], in3[1]};
  end

  // Second AND stage: t3 and t4 from registered t1, t2, a1, a2
  always_comb begin
    logic [2:0] n1t, ntt;
    n1t = dom_and(~p1_1_q[0], p1_2_q[0], p1_3_q[0], ~p1_1_q[3], p1_2_q[3], p1_3_q[3], rnd[4], rnd[5]);
    ntt = dom_and(~p1_1_q[3], p1_2_q[3], p1_3_q[3], ~p1_1_q[2], p1_2_q[2], p1_3_q[2], rnd[6], rnd[7]);
    p2_1_d = {p1_1_q[3:2], p1_1_q[1] ^ n1t[0], p1_1_q[0] ^ ntt[0]};
    p2_2_d = {p1_2_q[3:2], p1_2_q[1] ^ n1t[1], p1_2_q[0] ^ ntt[1]};
    p2_3_d = {p1_3_q[3:2], p1_3_q[1] ^ n1t[2], p1_3_q[0] ^ ntt[2]};
  end

  // Pipeline registers: two AND stages, then LAT-2 output delay stages
  always_ff @(posedge clk) begin
    if (rst) begin
      p1_1_q <= '0; p1_2_q <= '0; p1_3_q <= '0;
      p2_1_q <= '0; p2_2_q <= '0; p2_3_q <= '0;
      for (int k = 0; k < LAT-2; k++) dly_q[k] <= '0;
    end else begin
      p1_1_q <= p1_1_d; p1_2_q <= p1_2_d; p1_3_q <= p1_3_d;
      p2_1_q <= p2_1_d; p2_2_q <= p2_2_d; p2_3_q <= p2_3_d;
      dly_q[0] <= {p2_3_q, p2_2_q, p2_1_q};
      for (int k = 1; k < LAT-2; k++) dly_q[k] <= dly_q[k-1];
    end
  end

  assign out1 = dly_q[LAT-3][3:0];
  assign out2 = dly_q[LAT-3][7:4];
  assign out3 = dly_q[LAT-3][11:8];

endmodule

// File: rtl/skinny_sbox_layer_serial.sv
// Nibble-serial masked SKINNY-64 S-box layer over three Boolean shares.
// Latency: NIBBLES+SBOX_LAT+1 cycles from accepted start to the done-high cycle.
// Backpressure: none; start is only accepted in IDLE and ignored while busy or in DONE.
module skinny_sbox_layer_serial #(
  parameter int NIBBLES  = skinny_masked_pkg::NIBBLES,
  parameter int SBOX_LAT = skinny_masked_pkg::SBOX_LAT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] in_s0,
  input  logic [4*NIBBLES-1:0] in_s1,
  input  logic [4*NIBBLES-1:0] in_s2,
  input  logic [7:0]           rnd,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] out_s0,
  output logic [4*NIBBLES-1:0] out_s1,
  output logic [4*NIBBLES-1:0] out_s2
);

  import skinny_masked_pkg::*;

  localparam int         W         = 4 * NIBBLES;
  localparam logic [4:0] CAP_FIRST = 5'(SBOX_LAT);
  localparam logic [4:0] CNT_LAST  = 5'(NIBBLES + SBOX_LAT - 1);

  layer_state_t state_q, state_d;
  logic [4:0]   cnt_q;
  logic [W-1:0] feed0_q, feed1_q, feed2_q;
  logic [W-1:0] res0_q, res1_q, res2_q;
  logic [3:0]   core_o1, core_o2, core_o3;
  logic         load, run;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state and control: start only counts in IDLE, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    run     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        run = 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

  // Feed shift, output capture and cycle counter; the core sees feed flops directly
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      feed0_q <= '0; feed1_q <= '0; feed2_q <= '0;
      res0_q  <= '0; res1_q  <= '0; res2_q  <= '0;
    end else if (load) begin
      cnt_q   <= '0;
      feed0_q <= in_s0;
      feed1_q <= in_s1;
      feed2_q <= in_s2;
    end else if (run) begin
      cnt_q   <= cnt_q + 5'd1;
      feed0_q <= {feed0_q[W-5:0], 4'h0};
      feed1_q <= {feed1_q[W-5:0], 4'h0};
      feed2_q <= {feed2_q[W-5:0], 4'h0};
      // Core output for nibble i arrives SBOX_LAT cycles after it was presented
      if (cnt_q >= CAP_FIRST && cnt_q <= CNT_LAST) begin
        res0_q <= {res0_q[W-5:0], core_o1};
        res1_q <= {res1_q[W-5:0], core_o2};
        res2_q <= {res2_q[W-5:0], core_o3};
      end
    end
  end

  skinny_sbox_layer_serial_core #(
    .LAT (SBOX_LAT)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .in1  (feed0_q[W-1:W-4]),
    .in2  (feed1_q[W-1:W-4]),
    .in3  (feed2_q[W-1:W-4]),
    .rnd  (rnd),
    .out1 (core_o1),
    .out2 (core_o2),
    .out3 (core_o3)
  );

  assign out_s0 = res0_q;
  assign out_s1 = res1_q;
  assign out_s2 = res2_q;

endmodule

// File: tb/tb_skinny_sbox_layer_serial.sv
// Self-checking bench for skinny_sbox_layer_serial against a table-based S-box layer model.
// Latency: expects done in the 20th cycle counted from the accepted-start edge.
// Backpressure: exercises ignored starts in RUN/DONE and a mid-layer reset.
module tb_skinny_sbox_layer_serial;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [63:0] in_s0, in_s1, in_s2;
  logic [7:0]  rnd;
  logic        busy, done;
  logic [63:0] out_s0, out_s1, out_s2;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [63:0] TB_SBOX = 64'hF7E4D583B2A1096C;

  always #5 clk = ~clk;

  skinny_sbox_layer_serial dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .in_s0  (in_s0),
    .in_s1  (in_s1),
    .in_s2  (in_s2),
    .rnd    (rnd),
    .busy   (busy),
    .done   (done),
    .out_s0 (out_s0),
    .out_s1 (out_s1),
    .out_s2 (out_s2)
  );

  // Fresh randomness every cycle, changed well away from the rising edge
  initial begin
    rnd = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      rnd = 8'($urandom);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] ref_layer(input logic [63:0] x);
    logic [63:0] tab;
    logic [63:0] r;
    int          idx;
    tab = TB_SBOX;
    r   = '0;
    for (int k = 0; k < 16; k++) begin
      idx = int'(x[4*k +: 4]);
      r[4*k +: 4] = tab[4*idx +: 4];
    end
    return r;
  endfunction

  function automatic logic [63:0] rand64();
    return {32'($urandom), 32'($urandom)};
  endfunction

  // Start already driven at the current negedge; follow the layer to its done pulse
  task automatic collect_layer(output int lat, output logic [63:0] o0, output logic [63:0] o1,
                               output logic [63:0] o2);
    int c;
    lat = 999; o0 = '0; o1 = '0; o2 = '0;
    @(negedge clk);
    start = 1'b0;
    c = 1;
    check("busy_after_start", 64'(busy), 64'd1);
    while (c < 40) begin
      @(negedge clk);
      c++;
      if (done) begin
        lat = c;
        o0 = out_s0; o1 = out_s1; o2 = out_s2;
        break;
      end
    end
    if (lat != 999) begin
      @(negedge clk);
      check("done_one_cycle", {62'd0, done, busy}, 64'd0);
    end
  endtask

  task automatic run_layer(input logic [63:0] s0, input logic [63:0] s1, input logic [63:0] s2,
                           output int lat, output logic [63:0] o0, output logic [63:0] o1,
                           output logic [63:0] o2);
    @(negedge clk);
    if (done) @(negedge clk);
    in_s0 = s0; in_s1 = s1; in_s2 = s2;
    start = 1'b1;
    collect_layer(lat, o0, o1, o2);
  endtask

  initial begin
    int          lat, c, pulses, first, last_done, stab;
    logic [63:0] o0, o1, o2, x, m1, m2, u, exp_v, snap;

    rst = 1'b1; start = 1'b0;
    in_s0 = '0; in_s1 = '0; in_s2 = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_outs", out_s0 | out_s1 | out_s2, 64'd0);
    rst = 1'b0;

    // All-zero state
    run_layer(64'd0, 64'd0, 64'd0, lat, o0, o1, o2);
    check("zero_latency", 64'(lat), 64'd20);
    check("zero_value", o0 ^ o1 ^ o2, 64'hCCCCCCCCCCCCCCCC);

    // Known vector under random masks
    x = 64'h0123456789ABCDEF;
    for (int i = 0; i < 100; i++) begin
      m1 = rand64(); m2 = rand64();
      run_layer(x ^ m1 ^ m2, m1, m2, lat, o0, o1, o2);
      u = o0 ^ o1 ^ o2;
      check("kat_latency", 64'(lat), 64'd20);
      check("kat_value", u, 64'hC6901A2B385D4E7F);
      check("kat_share_leak", {61'd0, o0 == u, o1 == u, o2 == u}, 64'd0);
    end

    // Random states, plus outputs hold while idle
    for (int i = 0; i < 20; i++) begin
      x = rand64(); m1 = rand64(); m2 = rand64();
      run_layer(x ^ m1 ^ m2, m1, m2, lat, o0, o1, o2);
      check("rand_value", o0 ^ o1 ^ o2, ref_layer(x));
      repeat (3) @(negedge clk);
      check("idle_hold", {out_s0 ^ o0} | {out_s1 ^ o1} | {out_s2 ^ o2}, 64'd0);
    end

    // Extra start pulses during RUN with different inputs must be ignored
    x = rand64(); m1 = rand64(); m2 = rand64();
    exp_v = ref_layer(x);
    @(negedge clk);
    in_s0 = x ^ m1 ^ m2; in_s1 = m1; in_s2 = m2;
    start = 1'b1;
    pulses = 0; first = 0; o0 = '0; o1 = '0; o2 = '0;
    for (c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 5 || c == 12);
      if (start) begin
        in_s0 = rand64(); in_s1 = rand64(); in_s2 = rand64();
      end
      if (done) begin
        pulses++;
        if (first == 0) begin
          first = c;
          o0 = out_s0; o1 = out_s1; o2 = out_s2;
        end
      end
    end
    start = 1'b0;
    check("restart_pulses", 64'(pulses), 64'd1);
    check("restart_latency", 64'(first), 64'd20);
    check("restart_value", o0 ^ o1 ^ o2, exp_v);

    // Reset in the middle of a layer aborts it
    x = rand64(); m1 = rand64(); m2 = rand64();
    @(negedge clk);
    in_s0 = x ^ m1 ^ m2; in_s1 = m1; in_s2 = m2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (c = 2; c <= 11; c++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort_no_done", 64'(pulses) | 64'(done), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_outs", out_s0 | out_s1 | out_s2, 64'd0);
    rst = 1'b0;
    x = rand64(); m1 = rand64(); m2 = rand64();
    in_s0 = x ^ m1 ^ m2; in_s1 = m1; in_s2 = m2;
    start = 1'b1;
    collect_layer(lat, o0, o1, o2);
    check("post_rst_latency", 64'(lat), 64'd20);
    check("post_rst_value", o0 ^ o1 ^ o2, ref_layer(x));

    // Start held high: back-to-back layers, DONE-cycle start ignored
    x = rand64(); m1 = rand64(); m2 = rand64();
    exp_v = ref_layer(x);
    @(negedge clk);
    in_s0 = x ^ m1 ^ m2; in_s1 = m1; in_s2 = m2;
    start = 1'b1;
    pulses = 0; last_done = 0; stab = 0; snap = '0;
    o0 = '0; o1 = '0; o2 = '0;
    for (c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (pulses == 1) check("b2b_first_latency", 64'(c), 64'd20);
        else             check("b2b_interval", 64'(c - last_done), 64'd21);
        check("b2b_value", out_s0 ^ out_s1 ^ out_s2, exp_v);
        last_done = c;
        o0 = out_s0; o1 = out_s1; o2 = out_s2;
        stab = 4;
        if (pulses == 4) break;
      end else if (stab > 0) begin
        check("b2b_hold", {out_s0 ^ o0} | {out_s1 ^ o1} | {out_s2 ^ o2}, 64'd0);
        stab--;
      end
    end
    start = 1'b0;
    check("b2b_pulses", 64'(pulses), 64'd4);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
